// File: rtl/udma_spim_cmd_seq.sv
// ----------------------------------------------------------------------------
// udma_spim_cmd_seq
//
// Command sequencer between the SPI master's command uDMA channel and the SPI
// protocol controller. It accepts one 32-bit command word at a time and:
//   UCA  (4'hD) : programs the TX/RX channel start address in the accept cycle
//   UCS  (4'hE) : waits for the selected channel to be idle, then loads size /
//                 datasize and pulses that channel's enable for one cycle
//   WAIT (4'h5) : stalls for cmd[7:0] cycles after the accept cycle
//   EOT  (4'h9) : waits for both channels idle, then pulses eot_o
//   others      : forwarded unchanged to the controller
//
// Handshakes: a word moves on a rising clk_i edge when valid and ready are
// both high. cmd_ready_o is high only in IDLE. ctrl_valid_o, once high, holds
// ctrl_data_o stable and stays high until ctrl_ready_i is seen with it.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   cmd_data_i/valid_i/ready_o   command word input stream
//   ctrl_data_o/valid_o/ready_i  forwarded word output stream
//   tx_* / rx_*                  channel setup outputs, busy inputs
//   eot_o                        one-cycle end-of-transfer pulse
//   busy_o                       high whenever the FSM is not in IDLE
//   dbg_state_o                  current FSM state, for observation only
// ----------------------------------------------------------------------------
module udma_spim_cmd_seq #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [31:0]               cmd_data_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  output logic [31:0]               ctrl_data_o,
  output logic                      ctrl_valid_o,
  input  logic                      ctrl_ready_i,
  output logic [L2_AWIDTH_NOAL-1:0] tx_startaddr_o,
  output logic [L2_AWIDTH_NOAL-1:0] rx_startaddr_o,
  output logic [TRANS_SIZE-1:0]     tx_size_o,
  output logic [TRANS_SIZE-1:0]     rx_size_o,
  output logic [1:0]                tx_datasize_o,
  output logic [1:0]                rx_datasize_o,
  output logic                      tx_en_o,
  output logic                      rx_en_o,
  input  logic                      tx_busy_i,
  input  logic                      rx_busy_i,
  output logic                      eot_o,
  output logic                      busy_o,
  output logic [2:0]                dbg_state_o
);

  localparam logic [3:0] OP_UCA  = 4'hD;
  localparam logic [3:0] OP_UCS  = 4'hE;
  localparam logic [3:0] OP_WAIT = 4'h5;
  localparam logic [3:0] OP_EOT  = 4'h9;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FWD      = 3'd1;
  localparam logic [2:0] S_SETUP    = 3'd2;
  localparam logic [2:0] S_DELAY    = 3'd3;
  localparam logic [2:0] S_EOT_WAIT = 3'd4;

  logic [2:0]                r_state;
  logic [31:0]               r_cmd;
  logic [7:0]                r_cnt;
  logic [L2_AWIDTH_NOAL-1:0] r_tx_addr;
  logic [L2_AWIDTH_NOAL-1:0] r_rx_addr;
  logic [TRANS_SIZE-1:0]     r_tx_size;
  logic [TRANS_SIZE-1:0]     r_rx_size;
  logic [1:0]                r_tx_ds;
  logic [1:0]                r_rx_ds;

  logic [3:0]            w_op;
  logic                  w_sel_busy;
  logic                  w_setup_go;
  logic                  w_eot_go;
  logic [TRANS_SIZE-1:0] w_size;
  logic [1:0]            w_ds;

  assign w_op       = cmd_data_i[31:28];
  assign w_sel_busy = r_cmd[27] ? tx_busy_i : rx_busy_i;
  assign w_size     = r_cmd[TRANS_SIZE-1:0];
  assign w_ds       = r_cmd[26:25];

  // The busy checks are combinational so that a busy_i falling in the check
  // cycle counts as idle and the enable/EOT pulse appears in that same cycle.
  // rst_i masks them so a reset never lets a pending pulse escape.
  assign w_setup_go = (r_state == S_SETUP) && !w_sel_busy && !rst_i;
  assign w_eot_go   = (r_state == S_EOT_WAIT) && !tx_busy_i && !rx_busy_i && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_cmd     <= '0;
      r_cnt     <= '0;
      r_tx_addr <= '0;
      r_rx_addr <= '0;
      r_tx_size <= '0;
      r_rx_size <= '0;
      r_tx_ds   <= 2'b10;
      r_rx_ds   <= 2'b10;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            r_cmd <= cmd_data_i;
            case (w_op)
              OP_UCA: begin
                if (cmd_data_i[27]) r_tx_addr <= cmd_data_i[L2_AWIDTH_NOAL-1:0];
                else                r_rx_addr <= cmd_data_i[L2_AWIDTH_NOAL-1:0];
              end
              OP_UCS: r_state <= S_SETUP;
              OP_WAIT: begin
                // A zero count completes in the accept cycle itself.
                if (cmd_data_i[7:0] != 8'd0) begin
                  r_cnt   <= cmd_data_i[7:0];
                  r_state <= S_DELAY;
                end
              end
              OP_EOT:  r_state <= S_EOT_WAIT;
              default: r_state <= S_FWD;
            endcase
          end
        end
        S_FWD: begin
          if (ctrl_ready_i) r_state <= S_IDLE;
        end
        S_SETUP: begin
          if (w_setup_go) begin
            if (r_cmd[27]) begin
              r_tx_size <= w_size;
              r_tx_ds   <= w_ds;
            end else begin
              r_rx_size <= w_size;
              r_rx_ds   <= w_ds;
            end
            r_state <= S_IDLE;
          end
        end
        S_DELAY: begin
          // Counter runs N..1, giving exactly N stall cycles.
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) r_state <= S_IDLE;
        end
        S_EOT_WAIT: begin
          if (w_eot_go) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o    = (r_state == S_IDLE);
  assign ctrl_valid_o   = (r_state == S_FWD);
  assign ctrl_data_o    = r_cmd;
  assign tx_startaddr_o = r_tx_addr;
  assign rx_startaddr_o = r_rx_addr;
  assign tx_en_o        = w_setup_go && r_cmd[27];
  assign rx_en_o        = w_setup_go && !r_cmd[27];
  // During the enable pulse the new size/datasize are shown directly from the
  // command; the registers take them at the end of that cycle and hold them.
  assign tx_size_o      = tx_en_o ? w_size : r_tx_size;
  assign rx_size_o      = rx_en_o ? w_size : r_rx_size;
  assign tx_datasize_o  = tx_en_o ? w_ds : r_tx_ds;
  assign rx_datasize_o  = rx_en_o ? w_ds : r_rx_ds;
  assign eot_o          = w_eot_go;
  assign busy_o         = (r_state != S_IDLE);
  assign dbg_state_o    = r_state;

endmodule

// File: tb/tb_udma_spim_cmd_seq.sv
// ----------------------------------------------------------------------------
// tb_udma_spim_cmd_seq
//
// Directed bench for udma_spim_cmd_seq. Inputs are driven 1 time unit after
// the rising edge; outputs are sampled at that point or 1 unit later when a
// combinational output depends on an input just changed.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_udma_spim_cmd_seq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] cmd_data_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [31:0] ctrl_data_o;
  logic        ctrl_valid_o;
  logic        ctrl_ready_i;
  logic [11:0] tx_startaddr_o;
  logic [11:0] rx_startaddr_o;
  logic [15:0] tx_size_o;
  logic [15:0] rx_size_o;
  logic [1:0]  tx_datasize_o;
  logic [1:0]  rx_datasize_o;
  logic        tx_en_o;
  logic        rx_en_o;
  logic        tx_busy_i;
  logic        rx_busy_i;
  logic        eot_o;
  logic        busy_o;
  logic [2:0]  dbg_state_o;

  int tests = 0;
  int fails = 0;
  int hs_cnt = 0;
  int tx_en_cnt = 0;
  int rx_en_cnt = 0;
  int eot_cnt = 0;

  udma_spim_cmd_seq #(.L2_AWIDTH_NOAL(12), .TRANS_SIZE(16)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cmd_data_i     (cmd_data_i),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .ctrl_data_o    (ctrl_data_o),
    .ctrl_valid_o   (ctrl_valid_o),
    .ctrl_ready_i   (ctrl_ready_i),
    .tx_startaddr_o (tx_startaddr_o),
    .rx_startaddr_o (rx_startaddr_o),
    .tx_size_o      (tx_size_o),
    .rx_size_o      (rx_size_o),
    .tx_datasize_o  (tx_datasize_o),
    .rx_datasize_o  (rx_datasize_o),
    .tx_en_o        (tx_en_o),
    .rx_en_o        (rx_en_o),
    .tx_busy_i      (tx_busy_i),
    .rx_busy_i      (rx_busy_i),
    .eot_o          (eot_o),
    .busy_o         (busy_o),
    .dbg_state_o    (dbg_state_o)
  );

  // clock / reset block
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500us");
    $fatal(1, "watchdog");
  end

  // event counters sampled at the active edge
  always @(posedge clk_i) begin
    if (ctrl_valid_o && ctrl_ready_i) hs_cnt++;
    if (tx_en_o) tx_en_cnt++;
    if (rx_en_o) rx_en_cnt++;
    if (eot_o) eot_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Presents a word and returns 1 unit after the edge that accepted it.
  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    cmd_data_i  = w;
    cmd_valid_i = 1'b1;
    while (!cmd_ready_o && n < 100) begin
      step();
      n++;
    end
    chk("accept_ready", {31'd0, cmd_ready_o}, 32'd1);
    step();
    cmd_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  initial begin
    int n;
    logic rdy_before;
    rst_i        = 1'b1;
    cmd_data_i   = '0;
    cmd_valid_i  = 1'b0;
    ctrl_ready_i = 1'b0;
    tx_busy_i    = 1'b0;
    rx_busy_i    = 1'b0;
    repeat (3) step();
    rst_i = 1'b0;

    // reset state
    chk("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("rst_ctrl_valid", {31'd0, ctrl_valid_o}, 32'd0);
    chk("rst_ctrl_data", ctrl_data_o, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_en", {30'd0, tx_en_o, rx_en_o}, 32'd0);
    chk("rst_eot", {31'd0, eot_o}, 32'd0);
    chk("rst_addr", {8'd0, tx_startaddr_o, rx_startaddr_o}, 32'd0);
    chk("rst_size", {tx_size_o, rx_size_o}, 32'd0);
    chk("rst_ds", {28'd0, tx_datasize_o, rx_datasize_o}, 32'hA);

    // UCA TX then UCS TX, channel idle
    send(32'hD800_0123);
    chk("uca_tx_addr", {20'd0, tx_startaddr_o}, 32'h123);
    chk("uca_rx_addr", {20'd0, rx_startaddr_o}, 32'h0);
    chk("uca_ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("uca_no_en", {30'd0, tx_en_o, rx_en_o}, 32'd0);
    send(32'hEA00_0040);
    chk("ucs_tx_en", {31'd0, tx_en_o}, 32'd1);
    chk("ucs_tx_size", {16'd0, tx_size_o}, 32'h40);
    chk("ucs_tx_ds", {30'd0, tx_datasize_o}, 32'h1);
    step();
    chk("ucs_tx_en_drop", {31'd0, tx_en_o}, 32'd0);
    chk("ucs_tx_size_hold", {16'd0, tx_size_o}, 32'h40);
    chk("ucs_tx_ds_hold", {30'd0, tx_datasize_o}, 32'h1);
    chk("ucs_ready_back", {31'd0, cmd_ready_o}, 32'd1);
    chk("ucs_tx_en_cnt", tx_en_cnt, 32'd1);

    // UCS RX while rx busy for 10 cycles
    rx_busy_i = 1'b1;
    send(32'hE200_0020);
    for (int i = 0; i < 10; i++) begin
      chk("ucsrx_stall_en", {31'd0, rx_en_o}, 32'd0);
      chk("ucsrx_stall_rdy", {31'd0, cmd_ready_o}, 32'd0);
      step();
    end
    rx_busy_i = 1'b0;
    #1;
    chk("ucsrx_en", {31'd0, rx_en_o}, 32'd1);
    chk("ucsrx_size", {16'd0, rx_size_o}, 32'h20);
    chk("ucsrx_ds", {30'd0, rx_datasize_o}, 32'h1);
    step();
    chk("ucsrx_en_drop", {31'd0, rx_en_o}, 32'd0);
    chk("ucsrx_rx_en_cnt", rx_en_cnt, 32'd1);
    chk("ucsrx_ready", {31'd0, cmd_ready_o}, 32'd1);

    // WAIT 3 then forward; controller ready already high
    ctrl_ready_i = 1'b1;
    hs_cnt = 0;
    send(32'h5000_0003);
    cmd_data_i  = 32'h1000_0000;
    cmd_valid_i = 1'b1;
    n = 0;
    while (!ctrl_valid_o && n < 20) begin
      rdy_before = cmd_ready_o;
      step();
      n++;
      if (rdy_before) cmd_valid_i = 1'b0;
    end
    chk("wait3_latency", n, 32'd4);
    chk("wait3_fwd_data", ctrl_data_o, 32'h1000_0000);
    step();
    chk("wait3_fwd_done", {31'd0, ctrl_valid_o}, 32'd0);
    chk("wait3_hs_cnt", hs_cnt, 32'd1);
    ctrl_ready_i = 1'b0;

    // WAIT 0 completes immediately
    send(32'h5000_0000);
    chk("wait0_ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("wait0_busy", {31'd0, busy_o}, 32'd0);

    // forward with ctrl_ready low for 5 cycles
    hs_cnt = 0;
    send(32'h2ABC_0001);
    for (int i = 0; i < 5; i++) begin
      chk("fwd_hold_valid", {31'd0, ctrl_valid_o}, 32'd1);
      chk("fwd_hold_data", ctrl_data_o, 32'h2ABC_0001);
      if (i < 4) step();
    end
    ctrl_ready_i = 1'b1;
    step();
    ctrl_ready_i = 1'b0;
    chk("fwd_valid_drop", {31'd0, ctrl_valid_o}, 32'd0);
    chk("fwd_hs_cnt", hs_cnt, 32'd1);
    chk("fwd_ready", {31'd0, cmd_ready_o}, 32'd1);

    // EOT with rx busy through cycle 7
    eot_cnt = 0;
    rx_busy_i = 1'b1;
    send(32'h9000_0000);
    for (int c = 1; c <= 7; c++) begin
      chk("eot_wait_low", {31'd0, eot_o}, 32'd0);
      step();
    end
    rx_busy_i = 1'b0;
    #1;
    chk("eot_pulse", {31'd0, eot_o}, 32'd1);
    step();
    chk("eot_drop", {31'd0, eot_o}, 32'd0);
    chk("eot_cnt", eot_cnt, 32'd1);
    chk("eot_ready", {31'd0, cmd_ready_o}, 32'd1);

    // reset during SETUP
    tx_en_cnt = 0;
    tx_busy_i = 1'b1;
    send(32'hEC00_0080);
    chk("rsetup_busy", {31'd0, busy_o}, 32'd1);
    do_reset();
    tx_busy_i = 1'b0;
    #1;
    chk("rsetup_ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("rsetup_busy0", {31'd0, busy_o}, 32'd0);
    chk("rsetup_size", {tx_size_o, rx_size_o}, 32'd0);
    chk("rsetup_ds", {28'd0, tx_datasize_o, rx_datasize_o}, 32'hA);
    chk("rsetup_addr", {8'd0, tx_startaddr_o, rx_startaddr_o}, 32'd0);
    step();
    step();
    chk("rsetup_no_en", tx_en_cnt, 32'd0);

    // reset during DELAY
    send(32'h5000_00FF);
    step();
    chk("rdelay_busy", {31'd0, busy_o}, 32'd1);
    do_reset();
    chk("rdelay_ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("rdelay_ctrl_data", ctrl_data_o, 32'd0);
    step();
    chk("rdelay_idle", {29'd0, dbg_state_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/udma_spim_cmd_seq.md
# udma_spim_cmd_seq

Command sequencer between the SPI master's command uDMA channel and the SPI protocol controller. It consumes 32-bit command words and executes the channel-setup opcodes UCA and UCS locally by programming the TX/RX uDMA channels, stalling while the target channel is busy. It also executes WAIT (a cycle delay) and EOT (drain both channels, then flag completion). All other opcodes are forwarded unchanged to the controller over a valid/ready handshake.

## Interface
Parameters:
- L2_AWIDTH_NOAL, 12, L2 address width of channel start addresses
- TRANS_SIZE, 16, width of channel transfer size

Ports:
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  reset; synchronous, active-high
- cmd_data_i  in  32  command word; opcode in [31:28]
- cmd_valid_i  in  1  command word valid
- cmd_ready_o  out  1  command word accepted when high with cmd_valid_i
- ctrl_data_o  out  32  forwarded command word
- ctrl_valid_o  out  1  forwarded word valid
- ctrl_ready_i  in  1  controller accepts forwarded word
- tx_startaddr_o / rx_startaddr_o  out  L2_AWIDTH_NOAL  channel start address
- tx_size_o / rx_size_o  out  TRANS_SIZE  channel transfer size
- tx_datasize_o / rx_datasize_o  out  2  channel datasize
- tx_en_o / rx_en_o  out  1  one-cycle channel enable pulse
- tx_busy_i / rx_busy_i  in  1  channel enabled or pending
- eot_o  out  1  one-cycle end-of-transfer pulse
- busy_o  out  1  high whenever the state is not IDLE

## Operation
Opcodes:
- UCA = 4'hD
- UCS = 4'hE
- WAIT = 4'h5
- EOT = 4'h9
- Any other value = forward

Field decode:
- Bit [27]: 1 selects TX, 0 selects RX
- Bits [26:25]: datasize
- Low bits: address or size field
- Bits [7:0]: WAIT cycle count

State machine: IDLE, FWD, SETUP, DELAY, EOT_WAIT.
- IDLE:
  - cmd_ready_o = 1 only in IDLE.
  - On accept, the word is latched in r_cmd and the next state is chosen by opcode.
- UCA:
  - Executed in the accept cycle.
  - The selected startaddr_o is updated on the next edge.
  - No enable pulse; state stays IDLE.
- UCS → SETUP:
  - Wait while the selected busy_i = 1.
  - In the first cycle with busy_i = 0: load size_o and datasize_o, assert en_o for exactly one cycle, return to IDLE.
- WAIT:
  - Count 0 completes immediately; state stays IDLE.
  - Count N > 0 → DELAY; an 8-bit down-counter is loaded with N and IDLE is re-entered when it reaches 1.
  - Total stall is N cycles after the accept cycle.
- EOT → EOT_WAIT:
  - Wait until tx_busy_i = 0 and rx_busy_i = 0.
  - Then pulse eot_o for one cycle and return to IDLE.
- Other opcodes → FWD:
  - ctrl_valid_o = 1 with ctrl_data_o = r_cmd.
  - Data is held stable until ctrl_ready_i; then IDLE.
  - ctrl_valid_o never drops without a handshake.
- Commands execute strictly in order; no new word is accepted outside IDLE.

## Timing
Reset values:
- cmd_ready_o = 1 (IDLE)
- ctrl_valid_o, en pulses, eot_o, busy_o = 0
- ctrl_data_o, startaddr, size = 0
- Both datasize = 2'b10

Reset mid-operation:
- Next state is IDLE.
- Any pending forward, enable or EOT is dropped without a pulse.
- DELAY count is cleared.

Latencies from the accept edge:
- UCA: registers update at the same edge.
- UCS, channel idle: en_o high in cycle +1.
- UCS, channel busy: en_o high in the first cycle after busy_i falls.
- FWD: ctrl_valid_o high in cycle +1; next accept in the cycle after the handshake.
- EOT, channels idle: eot_o in cycle +1.

Back-to-back UCS to the same channel:
- The second busy check occurs no earlier than 2 cycles after the first en_o.
- The channel raises busy_i in the cycle after en_o, so the second UCS stalls correctly.

Simultaneous events:
- busy_i falling in the same cycle as the SETUP check counts as idle.
- ctrl_ready_i may be high before ctrl_valid_o; it is ignored until ctrl_valid_o = 1.

## Test plan
- Reset, then UCA 0xD800_0123 (TX), then UCS 0xEA00_0040 (TX, ds = 01, size = 0x40) → tx_startaddr_o = 0x123; tx_en_o pulses once with tx_size_o = 0x40, tx_datasize_o = 2'b01.
- UCS RX with rx_busy_i held high for 10 cycles → rx_en_o stays low and cmd_ready_o stays 0 throughout; rx_en_o pulses in the first cycle after rx_busy_i falls.
- WAIT 0x5000_0003 followed immediately by a forward 0x1000_0000 → ctrl_valid_o rises exactly 4 cycles after the WAIT accept.
- WAIT count 0 → next word accepted on the following cycle.
- Forward 0x2ABC_0001 with ctrl_ready_i low for 5 cycles → ctrl_valid_o and ctrl_data_o remain stable; exactly one handshake occurs.
- EOT with tx_busy_i low and rx_busy_i high until cycle 7 → eot_o pulses once in cycle 8.
- rst_i asserted during SETUP and during DELAY → outputs return to reset values on the next edge; no en_o pulse occurs.
